// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: a run/pause/idle FSM that issues one-cycle tick pulses
// on a programmable period, with merged speed-up requests applied at a wrap.
module game_tick_scheduler #(
    parameter int CNT_W       = 27,
    parameter int INIT_PERIOD = 50_000_000,
    parameter int MIN_PERIOD  = 5_000_000,
    parameter int STEP        = 5_000_000
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             resume,
    input  logic             stop,
    input  logic             speed_up,
    output logic             tick,
    output logic [15:0]      tick_count,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] INIT_P = CNT_W'(INIT_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] STEP_P = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W:0]   FLOOR  =
        (CNT_W + 1)'(MIN_PERIOD) + (CNT_W + 1)'(STEP);

    if (!(INIT_PERIOD >= MIN_PERIOD && MIN_PERIOD >= 2)) begin : g_param_check
        $fatal(1, "game_tick_scheduler: need INIT_PERIOD >= MIN_PERIOD >= 2");
    end

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_n;
    logic [CNT_W-1:0] period_n;
    logic [CNT_W-1:0] shorter;
    logic [15:0]      count_n;
    logic             tick_n;
    logic             pending;
    logic             pending_n;
    logic             wrap;

    // Compare against MIN+STEP first so the subtraction can never underflow.
    assign shorter = ({1'b0, period} >= FLOOR) ? period - STEP_P : MIN_P;
    assign state   = state_q;

    always_comb begin
        state_n   = state_q;
        counter_n = counter;
        tick_n    = 1'b0;
        count_n   = tick_count;
        period_n  = period;
        pending_n = pending;
        wrap      = 1'b0;

        unique case (state_q)
            IDLE: begin
                counter_n = '0;
                pending_n = 1'b0;
                if (start) begin
                    state_n  = RUN;
                    count_n  = '0;
                    period_n = INIT_P;
                end
            end
            RUN: begin
                wrap      = (counter == period - ONE);
                counter_n = wrap ? '0 : counter + ONE;
                tick_n    = wrap && !pause;
                if (pause) begin
                    state_n = PAUSED;
                end
            end
            PAUSED: begin
                if (resume) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n   = IDLE;
                counter_n = '0;
                pending_n = 1'b0;
            end
        endcase

        if (wrap && pending) begin
            period_n  = shorter;
            pending_n = 1'b0;
        end

        // A request arriving on the applying wrap waits for the next one.
        if (state_q != IDLE && speed_up) begin
            pending_n = 1'b1;
        end

        if (tick_n && tick_count != 16'hFFFF) begin
            count_n = tick_count + 16'd1;
        end

        if (stop) begin
            state_n   = IDLE;
            counter_n = '0;
            tick_n    = 1'b0;
            count_n   = tick_count;
            period_n  = period;
            pending_n = 1'b0;
        end
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_q    <= IDLE;
            counter    <= '0;
            tick       <= 1'b0;
            tick_count <= '0;
            period     <= INIT_P;
            pending    <= 1'b0;
        end else begin
            state_q    <= state_n;
            counter    <= counter_n;
            tick       <= tick_n;
            tick_count <= count_n;
            period     <= period_n;
            pending    <= pending_n;
        end
    end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: directed scenarios plus random commands,
// compared each cycle against a remaining-cycles reference model.
module tb_game_tick_scheduler;

    localparam int CW = 8;
    localparam int IP = 10;
    localparam int MP = 4;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          resume = 1'b0;
    logic          stop = 1'b0;
    logic          speed_up = 1'b0;
    logic          tick;
    logic [15:0]   tick_count;
    logic [CW-1:0] period;
    logic [1:0]    state;

    int total = 0;
    int bad = 0;

    // Reference model: state, cycles left in the current period, period,
    // tick count, tick output and the pending speed-up flag.
    int ms = 0;
    int rem = IP;
    int mp = IP;
    int mc = 0;
    int mt = 0;
    int pend = 0;

    always #5 clk = ~clk;

    game_tick_scheduler #(
        .CNT_W(CW),
        .INIT_PERIOD(IP),
        .MIN_PERIOD(MP),
        .STEP(ST)
    ) dut (
        .clkIn(clk),
        .reset(reset),
        .start(start),
        .pause(pause),
        .resume(resume),
        .stop(stop),
        .speed_up(speed_up),
        .tick(tick),
        .tick_count(tick_count),
        .period(period),
        .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int was;
        int boundary;
        was = ms;
        boundary = 0;
        mt = 0;
        if (reset) begin
            ms = 0; rem = IP; mp = IP; mc = 0; pend = 0;
            return;
        end
        if (stop) begin
            ms = 0; pend = 0;
            return;
        end
        if (ms == 0) begin
            if (start) begin
                ms = 1; rem = IP; mp = IP; mc = 0;
            end
        end else if (ms == 1) begin
            rem = rem - 1;
            if (rem == 0) boundary = 1;
            if (boundary == 1 && !pause) begin
                mt = 1;
                if (mc < 65535) mc = mc + 1;
            end
            if (pause) ms = 2;
        end else begin
            if (resume) ms = 1;
        end
        if (boundary == 1) begin
            if (pend == 1) begin
                mp = (mp - ST < MP) ? MP : mp - ST;
                pend = 0;
            end
            rem = mp;
        end
        if (was != 0 && speed_up) pend = 1;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".state"}, 32'(state), 32'(ms));
        check({tag, ".tick"}, 32'(tick), 32'(mt));
        check({tag, ".count"}, 32'(tick_count), 32'(mc));
        check({tag, ".period"}, 32'(period), 32'(mp));
        {reset, start, pause, resume, stop, speed_up} = '0;
    endtask

    initial begin
        int got;

        reset = 1'b1; cycle("rst");
        reset = 1'b1; cycle("rst");
        check("rst_state", 32'(state), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_count", 32'(tick_count), 0);
        check("rst_period", 32'(period), 10);

        start = 1'b1; cycle("start");
        for (int k = 1; k <= 30; k++) begin
            cycle("run");
            check("tick_at", 32'(tick), 32'(k % 10 == 0));
        end
        check("count3", 32'(tick_count), 3);

        repeat (4) cycle("pre");
        pause = 1'b1; cycle("pause");
        check("paused", 32'(state), 2);
        for (int k = 0; k < 7; k++) begin
            cycle("hold");
            check("hold_tick", 32'(tick), 0);
            check("hold_cnt", 32'(tick_count), 3);
        end
        resume = 1'b1; cycle("resume");
        check("resumed", 32'(state), 1);
        for (int j = 1; j <= 5; j++) begin
            cycle("after");
            check("resume_tick", 32'(tick), 32'(j == 5));
        end

        for (int k = 0; k < 3; k++) begin
            speed_up = 1'b1; cycle("su3");
        end
        for (int j = 1; j <= 7; j++) begin
            cycle("p7");
            check("p7_period", 32'(period), (j == 7) ? 7 : 10);
            check("p7_tick", 32'(tick), 32'(j == 7));
        end
        speed_up = 1'b1; cycle("su1");
        for (int j = 1; j <= 6; j++) begin
            cycle("p4");
            check("p4_period", 32'(period), (j == 6) ? 4 : 7);
        end
        speed_up = 1'b1; cycle("su2");
        for (int j = 1; j <= 3; j++) begin
            cycle("clamp");
            check("clamp_tick", 32'(tick), 32'(j == 3));
        end
        check("clamp_period", 32'(period), 4);

        speed_up = 1'b1; cycle("su4");
        stop = 1'b1; pause = 1'b1; cycle("stop");
        check("stop_state", 32'(state), 0);
        for (int k = 0; k < 12; k++) begin
            cycle("idle");
            check("idle_tick", 32'(tick), 0);
        end
        start = 1'b1; cycle("restart");
        for (int k = 1; k <= 10; k++) begin
            cycle("re");
            check("re_tick", 32'(tick), 32'(k == 10));
        end
        check("re_period", 32'(period), 10);
        check("re_count", 32'(tick_count), 1);

        repeat (8) cycle("to8");
        reset = 1'b1; cycle("midrst");
        check("mr_state", 32'(state), 0);
        check("mr_tick", 32'(tick), 0);
        check("mr_count", 32'(tick_count), 0);
        check("mr_period", 32'(period), 10);
        for (int k = 0; k < 2; k++) begin
            cycle("mr_after");
            check("mr_notick", 32'(tick), 0);
        end

        for (int k = 0; k < 4000; k++) begin
            reset    = ($urandom_range(0, 499) == 0);
            start    = ($urandom_range(0, 19) == 0);
            pause    = ($urandom_range(0, 29) == 0);
            resume   = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 99) == 0);
            speed_up = ($urandom_range(0, 24) == 0);
            cycle("rnd");
        end

        reset = 1'b1; cycle("sat_rst");
        start = 1'b1; cycle("sat_start");
        force dut.tick_count = 16'hFFFE;
        mc = 16'hFFFE;
        cycle("sat_force");
        release dut.tick_count;
        #1;
        check("sat_held", 32'(tick_count), 32'h0000_FFFE);
        for (int n = 0; n < 2; n++) begin
            got = 0;
            for (int i = 0; i < 20 && got == 0; i++) begin
                cycle("sat");
                got = int'(tick);
            end
            check("sat_tick_seen", 32'(got), 1);
            check("sat_value", 32'(tick_count), 32'h0000_FFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
